// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage: PC register, ROM request and the
//               IF/ID pipeline register (stall, delay-slot branch, flush).
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid
);

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    logic              r_rom_ce;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_id_pc;
    logic [INST_W-1:0] r_id_inst;
    logic              r_id_valid;

    logic [ADDR_W-1:0] w_flush_pc;
    logic [ADDR_W-1:0] w_branch_pc;
    logic [ADDR_W-1:0] w_seq_pc;

    // Redirect targets are word-aligned by dropping the byte-offset bits.
    assign w_flush_pc  = {flush_pc[ADDR_W-1:2], 2'b00};
    assign w_branch_pc = {branch_target[ADDR_W-1:2], 2'b00};
    assign w_seq_pc    = r_pc + c_PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_ce   <= 1'b0;
            r_pc       <= RESET_PC;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else if (!r_rom_ce) begin
            // First cycle out of reset only enables the ROM; fetch starts next.
            r_rom_ce <= 1'b1;
        end else if (flush) begin
            r_pc       <= w_flush_pc;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else if (!stall) begin
            r_pc       <= branch_taken ? w_branch_pc : w_seq_pc;
            r_id_pc    <= r_pc;
            r_id_inst  <= rom_inst;
            r_id_valid <= 1'b1;
        end
    end

    assign rom_ce   = r_rom_ce;
    assign rom_addr = r_pc;
    assign id_pc    = r_id_pc;
    assign id_inst  = r_id_inst;
    assign id_valid = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Scoreboard bench for if_stage: directed plan plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    always #5 clk = ~clk;

    if_stage #(
        .ADDR_W  (32),
        .INST_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid)
    );

    // ROM contents: word k (byte address 4k) holds 32'h1000_0000 + k.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction
    assign rom_inst = rom_word(rom_addr);

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        v;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference: fetch state as the specification describes it.
    logic        m_ce   = 1'b0;
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_ipc  = 32'h0;
    logic [31:0] m_inst = 32'h0;
    logic        m_v    = 1'b0;

    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] fp,
                         input logic b, input logic [31:0] bt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; flush_pc = fp; branch_taken = b; branch_target = bt;
        if (r) begin
            m_ce = 0; m_pc = 32'h0; m_ipc = 0; m_inst = 0; m_v = 0;
        end else if (!m_ce) begin
            m_ce = 1;
        end else if (f) begin
            m_pc = fp & ~32'h3; m_ipc = 0; m_inst = 0; m_v = 0;
        end else if (!s) begin
            m_ipc  = m_pc;
            m_inst = rom_word(m_pc);
            m_v    = 1;
            m_pc   = b ? (bt & ~32'h3) : m_pc + 32'd4;
        end
        e.ce = m_ce; e.addr = m_pc; e.ipc = m_ipc; e.inst = m_inst; e.v = m_v;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rom_ce",   {31'b0, rom_ce},   {31'b0, e.ce});
                chk("rom_addr", rom_addr,          e.addr);
                chk("id_pc",    id_pc,             e.ipc);
                chk("id_inst",  id_inst,           e.inst);
                chk("id_valid", {31'b0, id_valid}, {31'b0, e.v});
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1; stall = 0; flush = 0; flush_pc = 0; branch_taken = 0; branch_target = 0;
        // Reset, sequential fetch up to rom_addr=8, then a 3-cycle stall.
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // Branch with delay slot at rom_addr=10.
        drive(0, 0, 0, 0, 1, 32'h40);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // Flush beats stall and branch together.
        drive(0, 1, 1, 32'h180, 1, 32'h80);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // Misaligned branch target and wrap past the top of the address space.
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // Reset during an active stall at rom_addr=20.
        drive(0, 0, 0, 0, 1, 32'h20);
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 32'h99);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom,
                  $urandom_range(0, 5) == 0,
                  $urandom);
        end
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
